// File: rtl/hazard_flush_if.sv
// Issue/redirect/load-completion bundle between decode, execute, memory and
// the hazard/flush controller. The controller sits on the slave side.
interface hazard_flush_if #(
    parameter int NUM_REGS       = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    // Decode -> controller: instruction presented for issue
    logic                      issue_valid;
    logic [REG_ADDR_WIDTH-1:0] issue_rs1;
    logic [REG_ADDR_WIDTH-1:0] issue_rs2;
    logic                      issue_uses_rs1;
    logic                      issue_uses_rs2;
    logic [REG_ADDR_WIDTH-1:0] issue_rd;
    logic                      issue_is_load;
    logic                      issue_is_fence;
    logic                      issue_ready;

    // Execute / memory -> controller
    logic                      ex_redirect;
    logic                      load_done;
    logic [REG_ADDR_WIDTH-1:0] load_done_rd;

    // Controller -> front end and observers
    logic                      flush_fetch;
    logic                      flush_decode;
    logic [NUM_REGS-1:0]       pending_mask;
    logic                      hazard_timeout;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
               issue_rd, issue_is_load, issue_is_fence,
               ex_redirect, load_done, load_done_rd,
        input  issue_ready, flush_fetch, flush_decode, pending_mask, hazard_timeout
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_uses_rs1, issue_uses_rs2,
               issue_rd, issue_is_load, issue_is_fence,
               ex_redirect, load_done, load_done_rd,
        output issue_ready, flush_fetch, flush_decode, pending_mask, hazard_timeout
    );
endinterface

// File: rtl/hazard_flush_controller.sv
// Issue sequencer between decode and execute. Tracks destination registers of
// in-flight loads, stalls load-use / WAW hazards, holds fences until all loads
// retire, and emits fixed-length fetch/decode flush pulses on a redirect.
module hazard_flush_controller #(
    parameter int NUM_REGS       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 2,
    parameter int STALL_TIMEOUT  = 255
) (
    input logic          clk,
    input logic          rst_n,
    hazard_flush_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    localparam int FLUSH_CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int STALL_CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(STALL_TIMEOUT);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_WIDTH-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    state_t                 state;
    state_t                 state_next;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_next;
    logic                   flush_q;
    logic [NUM_REGS-1:0]    pending_mask;
    logic [NUM_REGS-1:0]    pending_next;
    logic [NUM_REGS-1:0]    done_onehot;
    logic [NUM_REGS-1:0]    set_onehot;
    logic [NUM_REGS-1:0]    eff_pending;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [STALL_CNT_W-1:0] stall_next;
    logic                   timeout_q;
    logic                   hazard;
    logic                   fence_block;
    logic                   issue_ready;
    logic                   fire;

    // Scoreboard view with same-cycle load completion bypassed, hazard detect
    // and issue handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        done_onehot = '0;
        set_onehot  = '0;
        if (bus.load_done) begin
            done_onehot = onehot(bus.load_done_rd);
        end
        // Bit 0 is never set, so a completion naming x0 clears nothing.
        eff_pending = pending_mask & ~done_onehot;
        hazard      = (bus.issue_uses_rs1 & eff_pending[bus.issue_rs1])
                    | (bus.issue_uses_rs2 & eff_pending[bus.issue_rs2])
                    | (bus.issue_is_load  & eff_pending[bus.issue_rd]);
        fence_block = bus.issue_is_fence & (|eff_pending);
        issue_ready = (state == ST_RUN) & ~hazard & ~bus.ex_redirect & ~fence_block;
        fire        = bus.issue_valid & issue_ready;
        if (fire && bus.issue_is_load && (bus.issue_rd != '0)) begin
            set_onehot = onehot(bus.issue_rd);
        end
        // A load issuing to a register whose older load completes now keeps it pending.
        pending_next = (pending_mask & ~done_onehot) | set_onehot;
    end

    // Next-state logic: redirect beats everything, fences wait for the drain.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_RUN: begin
                if (bus.ex_redirect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (bus.issue_valid && fence_block) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.ex_redirect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (eff_pending == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (bus.ex_redirect) begin
                    flush_cnt_next = FLUSH_LOAD;
                end else if (flush_cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt - FLUSH_CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Stall length: counts refused cycles outside FLUSH, saturating at the limit.
    always_comb begin
        stall_next = stall_cnt;
        if (!bus.issue_valid || fire) begin
            stall_next = '0;
        end else if ((state != ST_FLUSH) && (stall_cnt != STALL_LIMIT)) begin
            stall_next = stall_cnt + STALL_CNT_W'(1);
        end
    end

    // Control state, flush pulse and flush length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            flush_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            flush_q   <= (state_next == ST_FLUSH);
        end
    end

    // Load scoreboard; flushes leave it alone since in-flight loads predate the branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any register.
            pending_mask <= '0;
        end else begin
            pending_mask <= pending_next;
        end
    end

    // Stall watchdog; the timeout flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_cnt <= stall_next;
            if (stall_next == STALL_LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.issue_ready    = issue_ready;
    assign bus.flush_fetch    = flush_q;
    assign bus.flush_decode   = flush_q;
    assign bus.pending_mask   = pending_mask;
    assign bus.hazard_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Directed bench for hazard_flush_controller. Stimulus pushes the expected
// per-cycle outputs into a queue; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_hazard_flush_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_flush_if bus ();

    hazard_flush_controller #(
        .NUM_REGS      (32),
        .REG_ADDR_WIDTH(5),
        .FLUSH_CYCLES  (2),
        .STALL_TIMEOUT (255)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string       name;
        logic        ready;
        logic        flush;
        logic [31:0] mask;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare everything expected for this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".issue_ready"},    32'(bus.issue_ready),    32'(e.ready));
            check({e.name, ".flush_fetch"},    32'(bus.flush_fetch),    32'(e.flush));
            check({e.name, ".flush_decode"},   32'(bus.flush_decode),   32'(e.flush));
            check({e.name, ".pending_mask"},   bus.pending_mask,        e.mask);
            check({e.name, ".hazard_timeout"}, 32'(bus.hazard_timeout), 32'(e.timeout));
        end
    end

    task automatic expect_out(input string name, input logic r, input logic f,
                              input logic [31:0] m, input logic t);
        exp_t e;
        e.name    = name;
        e.ready   = r;
        e.flush   = f;
        e.mask    = m;
        e.timeout = t;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.issue_rs1      = '0;
        bus.issue_rs2      = '0;
        bus.issue_uses_rs1 = 1'b0;
        bus.issue_uses_rs2 = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_is_load  = 1'b0;
        bus.issue_is_fence = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.load_done      = 1'b0;
        bus.load_done_rd   = '0;
    endtask

    // Advance one cycle; inputs return to idle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_load(input logic [4:0] rd);
        bus.issue_valid   = 1'b1;
        bus.issue_rd      = rd;
        bus.issue_is_load = 1'b1;
    endtask

    task automatic set_alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.issue_valid    = 1'b1;
        bus.issue_rs1      = rs1;
        bus.issue_rs2      = rs2;
        bus.issue_uses_rs1 = 1'b1;
        bus.issue_uses_rs2 = 1'b1;
        bus.issue_rd       = rd;
    endtask

    task automatic set_fence();
        bus.issue_valid    = 1'b1;
        bus.issue_is_fence = 1'b1;
    endtask

    task automatic done(input logic [4:0] rd);
        bus.load_done    = 1'b1;
        bus.load_done_rd = rd;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        idle();
        expect_out("reset", 1'b1, 1'b0, 32'h0, 1'b0);
        #12;
        rst_n = 1'b1;

        // 1: load-use stall on x5, released by same-cycle completion.
        step(); set_load(5);                   expect_out("t1_load_x5",   1, 0, 32'h0,  0);
        step(); set_alu(5, 1, 6);              expect_out("t1_use_stall", 0, 0, 32'h20, 0);
        step(); set_alu(5, 1, 6);              expect_out("t1_use_stall", 0, 0, 32'h20, 0);
        step(); set_alu(5, 1, 6); done(5);     expect_out("t1_bypass",    1, 0, 32'h20, 0);
        step();                                expect_out("t1_cleared",   1, 0, 32'h0,  0);

        // 2: WAW on x7; set wins over the simultaneous clear.
        step(); set_load(7);                   expect_out("t2_load_x7",   1, 0, 32'h0,  0);
        step(); set_load(7);                   expect_out("t2_waw_stall", 0, 0, 32'h80, 0);
        step(); set_load(7); done(7);          expect_out("t2_waw_fire",  1, 0, 32'h80, 0);
        step();                                expect_out("t2_set_wins",  1, 0, 32'h80, 0);
        step(); done(7);                       expect_out("t2_done_x7",   1, 0, 32'h80, 0);
        step(); done(0);                       expect_out("t2_done_x0",   1, 0, 32'h0,  0);
        step(); done(12);                      expect_out("t2_done_idle", 1, 0, 32'h0,  0);

        // 3: single redirect, presented load must not fire.
        step(); set_load(10); bus.ex_redirect = 1'b1; expect_out("t3_redirect", 0, 0, 32'h0, 0);
        step(); set_load(10);                  expect_out("t3_flush1",    0, 1, 32'h0,  0);
        step(); set_load(10);                  expect_out("t3_flush2",    0, 1, 32'h0,  0);
        step(); set_load(10);                  expect_out("t3_run",       1, 0, 32'h0,  0);
        step(); done(10);                      expect_out("t3_load_x10",  1, 0, 32'h400, 0);
        step();                                expect_out("t3_clear_x10", 1, 0, 32'h0,  0);
        // 3b: second redirect one cycle later stretches the flush.
        step(); bus.ex_redirect = 1'b1;        expect_out("t3b_redir0",   0, 0, 32'h0,  0);
        step(); bus.ex_redirect = 1'b1;        expect_out("t3b_redir1",   0, 1, 32'h0,  0);
        step();                                expect_out("t3b_flush2",   0, 1, 32'h0,  0);
        step();                                expect_out("t3b_flush3",   0, 1, 32'h0,  0);
        step();                                expect_out("t3b_run",      1, 0, 32'h0,  0);

        // 4: fence drains x3 and x4; load to x0 leaves the scoreboard alone.
        step(); set_load(3);                   expect_out("t4_load_x3",   1, 0, 32'h0,  0);
        step(); set_load(4);                   expect_out("t4_load_x4",   1, 0, 32'h08, 0);
        step(); set_fence();                   expect_out("t4_fence",     0, 0, 32'h18, 0);
        step(); set_fence(); done(3);          expect_out("t4_drain_d3",  0, 0, 32'h18, 0);
        step(); set_fence();                   expect_out("t4_drain",     0, 0, 32'h10, 0);
        step(); set_fence(); done(4);          expect_out("t4_drain_d4",  0, 0, 32'h10, 0);
        step(); set_fence();                   expect_out("t4_fence_go",  1, 0, 32'h0,  0);
        step(); set_load(0);                   expect_out("t4_load_x0",   1, 0, 32'h0,  0);
        step();                                expect_out("t4_x0_nomask", 1, 0, 32'h0,  0);

        // 5: dependent instruction held on x9 until the watchdog trips.
        step(); set_load(9);                   expect_out("t5_load_x9",   1, 0, 32'h0,  0);
        for (int i = 0; i < 255; i++) begin
            step(); bus.issue_valid = 1'b1; bus.issue_uses_rs1 = 1'b1;
            bus.issue_rs1 = 5'd9; bus.issue_rd = 5'd11;
            expect_out("t5_stall", 0, 0, 32'h200, 0);
        end
        step(); bus.issue_valid = 1'b1; bus.issue_uses_rs1 = 1'b1; bus.issue_rs1 = 5'd9;
        expect_out("t5_timeout", 0, 0, 32'h200, 1);
        step(); bus.issue_valid = 1'b1; bus.issue_uses_rs1 = 1'b1; bus.issue_rs1 = 5'd9; done(9);
        expect_out("t5_release", 1, 0, 32'h200, 1);
        step();                                expect_out("t5_sticky",    1, 0, 32'h0,  1);

        // 6: asynchronous reset in the middle of a flush with x3/x5 pending.
        step(); set_load(3);                   expect_out("t6_load_x3",   1, 0, 32'h0,  1);
        step(); set_load(5);                   expect_out("t6_load_x5",   1, 0, 32'h08, 1);
        step(); bus.ex_redirect = 1'b1;        expect_out("t6_redirect",  0, 0, 32'h28, 1);
        step();                                expect_out("t6_flush",     0, 1, 32'h28, 1);
        step(); bus.ex_redirect = 1'b1;
        #1 rst_n = 1'b0;                       expect_out("t6_async_rst", 0, 0, 32'h0,  0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.ex_redirect = 1'b0;
        step();                                expect_out("t6_after_rst", 1, 0, 32'h0,  0);
        step(); set_load(2);                   expect_out("t6_load_x2",   1, 0, 32'h0,  0);
        step();                                expect_out("t6_resumed",   1, 0, 32'h04, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
